// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWrite,
    StDone
  } state_e;

  // Default geometry; the controller recomputes these from its own parameters.
  localparam int unsigned NumLinesDef = 32;
  localparam int unsigned WpbDef      = 4;
  localparam int unsigned WORD_BITS   = $clog2(WpbDef);
  localparam int unsigned INDEX_BITS  = $clog2(NumLinesDef);
  localparam int unsigned TAG_BITS    = 32 - 2 - WORD_BITS - INDEX_BITS;

  // Word-within-block field, right-aligned in a 32-bit result.
  function automatic logic [31:0] addr_word(logic [31:0] addr, int unsigned word_bits);
    return (addr >> 2) & ((32'd1 << word_bits) - 32'd1);
  endfunction

  // Line index field, right-aligned in a 32-bit result.
  function automatic logic [31:0] addr_index(logic [31:0] addr, int unsigned word_bits,
                                             int unsigned index_bits);
    return (addr >> (2 + word_bits)) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  // Tag field, right-aligned in a 32-bit result.
  function automatic logic [31:0] addr_tag(logic [31:0] addr, int unsigned word_bits,
                                           int unsigned index_bits);
    return addr >> (2 + word_bits + index_bits);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous word-write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES       = NumLinesDef,
  parameter int unsigned WORDS_PER_BLOCK = WpbDef
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [$clog2(NUM_LINES)-1:0]         rd_index_i,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0]   rd_word_i,
  output logic                                 rd_valid_o,
  output logic [31-2-$clog2(WORDS_PER_BLOCK)-$clog2(NUM_LINES):0] rd_tag_o,
  output logic [31:0]                          rd_data_o,
  input  logic [$clog2(NUM_LINES)-1:0]         wr_index_i,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0]   wr_word_i,
  input  logic [31:0]                          wr_data_i,
  input  logic                                 wr_en_i,
  input  logic                                 set_valid_i,
  input  logic [31-2-$clog2(WORDS_PER_BLOCK)-$clog2(NUM_LINES):0] set_tag_i,
  input  logic                                 clr_valid_i
);

  localparam int unsigned WB = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TB = 30 - WB - IB;

  logic [NUM_LINES-1:0] valid_q;
  logic [TB-1:0]        tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][WORDS_PER_BLOCK];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];

  // Valid bits: cleared on reset, cleared when a fill starts, set when it completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (clr_valid_i) valid_q[wr_index_i] <= 1'b0;
      if (set_valid_i) valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag storage, written only when a fill completes; never reset.
  always_ff @(posedge clk_i) begin
    if (set_valid_i) tag_q[wr_index_i] <= set_tag_i;
  end

  // Data storage, one word per cycle; never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) data_q[wr_index_i][wr_word_i] <= wr_data_i;
  end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module data_cache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES       = NumLinesDef,
  parameter int unsigned WORDS_PER_BLOCK = WpbDef
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        hit,
  output logic [31:0] readData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData,
  input  logic        memReady
);

  localparam int unsigned WB = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TB = 30 - WB - IB;
  localparam logic [WB-1:0] LastWord = WB'(WORDS_PER_BLOCK - 1);

  state_e        state_q;
  logic [WB-1:0] wcnt_q;

  logic [31:0]   word_full, index_full, tag_full;
  logic [WB-1:0] word;
  logic [IB-1:0] index;
  logic [TB-1:0] tag;

  logic          rd_valid;
  logic [TB-1:0] rd_tag;
  logic [31:0]   rd_data;
  logic          line_hit;

  logic          wr_en, set_valid, clr_valid;
  logic [WB-1:0] wr_word;
  logic [31:0]   wr_data;
  logic          fill_last;

  assign word_full  = addr_word(address, WB);
  assign index_full = addr_index(address, WB, IB);
  assign tag_full   = addr_tag(address, WB, IB);
  assign word       = word_full[WB-1:0];
  assign index      = index_full[IB-1:0];
  assign tag        = tag_full[TB-1:0];

  // Upper helper bits are zero by construction; byte offset is ignored.
  logic unused_addr;
  assign unused_addr = ^{word_full[31:WB], index_full[31:IB], tag_full[31:TB], address[1:0]};

  dcache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
  ) u_array (
    .clk_i      (CLK),
    .rst_i      (RST),
    .rd_index_i (index),
    .rd_word_i  (word),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_index_i (index),
    .wr_word_i  (wr_word),
    .wr_data_i  (wr_data),
    .wr_en_i    (wr_en),
    .set_valid_i(set_valid),
    .set_tag_i  (tag),
    .clr_valid_i(clr_valid)
  );

  // Tags are only meaningful on valid lines.
  assign line_hit  = rd_valid && (rd_tag == tag);
  assign fill_last = (wcnt_q == LastWord);

  // Main FSM and fill word counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (MemWrite) begin
            state_q <= StWrite;
          end else if (MemRead && !line_hit) begin
            state_q <= StFill;
            wcnt_q  <= '0;
          end
        end
        StFill: begin
          if (memReady) begin
            wcnt_q <= wcnt_q + WB'(1);
            if (fill_last) state_q <= StIdle;
          end
        end
        StWrite: begin
          if (memReady) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array write-side control: fill beats, store hits, and line invalidation on miss.
  always_comb begin
    wr_en     = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    wr_word   = word;
    wr_data   = writeData;
    unique case (state_q)
      StIdle: clr_valid = !MemWrite && MemRead && !line_hit;
      StFill: begin
        wr_word   = wcnt_q;
        wr_data   = memReadData;
        wr_en     = memReady;
        set_valid = memReady && fill_last;
      end
      // No-write-allocate: only an already-resident word is updated.
      StWrite: wr_en = memReady && line_hit;
      default: ;
    endcase
  end

  // Pipeline-facing and memory-facing outputs.
  always_comb begin
    hit          = 1'b0;
    readData     = 32'h0;
    memReq       = 1'b0;
    memWe        = 1'b0;
    memAddr      = 32'h0;
    memWriteData = 32'h0;
    unique case (state_q)
      StIdle: begin
        hit = !MemWrite && (!MemRead || line_hit);
        if (MemRead && hit) readData = rd_data;
      end
      StFill: begin
        memReq  = 1'b1;
        memAddr = {tag, index, wcnt_q, 2'b00};
      end
      StWrite: begin
        memReq       = 1'b1;
        memWe        = 1'b1;
        memAddr      = {address[31:2], 2'b00};
        memWriteData = writeData;
      end
      StDone: hit = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller with a memory-backed scoreboard.
module tb_data_cache_controller;

  localparam int NL  = 32;
  localparam int WPB = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] address, writeData, memReadData;
  logic        MemRead, MemWrite, memReady;
  logic        hit, memReq, memWe;
  logic [31:0] readData, memAddr, memWriteData;

  data_cache_controller #(
    .NUM_LINES      (NL),
    .WORDS_PER_BLOCK(WPB)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .address     (address),
    .writeData   (writeData),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .hit         (hit),
    .readData    (readData),
    .memReq      (memReq),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memWriteData(memWriteData),
    .memReadData (memReadData),
    .memReady    (memReady)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          checks   = 0;
  int          failures = 0;
  int          beats    = 0;

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'hA500_0000 | a;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: answers every other cycle while memReq is high, logging each beat.
  initial begin
    bit gap;
    gap         = 1'b0;
    memReady    = 1'b0;
    memReadData = 32'h0;
    forever begin
      @(negedge CLK);
      #2;
      if (memReq === 1'b1 && !gap && RST === 1'b0) begin
        if (memWe) mem_model[memAddr] = memWriteData;
        memReadData = memWe ? 32'h0 : mem_rd(memAddr);
        log_q.push_back('{we: memWe, addr: memAddr, data: memWe ? memWriteData : memReadData});
        beats++;
        memReady = 1'b1;
        gap      = 1'b1;
      end else begin
        memReady = 1'b0;
        gap      = 1'b0;
      end
    end
  end

  // Waits (bounded) until hit; captures the first memory request seen.
  task automatic wait_hit(output int cyc, output logic req_seen, output logic cap_we,
                          output logic [31:0] cap_addr, output logic [31:0] cap_wd);
    cyc = 0; req_seen = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_wd = '0;
    while (hit !== 1'b1 && cyc < 64) begin
      @(negedge CLK);
      #1;
      cyc++;
      if (memReq === 1'b1 && !req_seen) begin
        req_seen = 1'b1; cap_we = memWe; cap_addr = memAddr; cap_wd = memWriteData;
      end
    end
    if (hit !== 1'b1) check("hit_timeout", {31'b0, hit}, 32'd1);
  endtask

  task automatic do_load(string tag, logic [31:0] addr, int exp_beats);
    int cyc; logic rs, cwe; logic [31:0] ca, cwd, base;
    @(negedge CLK);
    address = addr; MemRead = 1'b1; MemWrite = 1'b0;
    exp_q.push_back(mem_rd(addr));
    log_q.delete(); beats = 0;
    base = addr & ~32'(WPB * 4 - 1);
    #1;
    check({tag, "_hit0"}, {31'b0, hit}, (exp_beats == 0) ? 32'd1 : 32'd0);
    check({tag, "_req0"}, {31'b0, memReq}, 32'd0);
    wait_hit(cyc, rs, cwe, ca, cwd);
    check({tag, "_data"}, readData, exp_q.pop_front());
    check({tag, "_latency"}, cyc, 2 * exp_beats);
    check({tag, "_beats"}, beats, exp_beats);
    for (int i = 0; i < log_q.size(); i++) begin
      check({tag, "_fill_addr"}, log_q[i].addr, base + 32'(4 * i));
      check({tag, "_fill_we"}, {31'b0, log_q[i].we}, 32'd0);
    end
    @(negedge CLK);
    MemRead = 1'b0;
  endtask

  task automatic do_store(string tag, logic [31:0] addr, logic [31:0] data);
    int cyc; logic rs, cwe; logic [31:0] ca, cwd;
    @(negedge CLK);
    address = addr; writeData = data; MemWrite = 1'b1; MemRead = 1'b0;
    log_q.delete(); beats = 0;
    #1;
    check({tag, "_hit0"}, {31'b0, hit}, 32'd0);
    wait_hit(cyc, rs, cwe, ca, cwd);
    check({tag, "_latency"}, cyc, 2);
    check({tag, "_req"}, {31'b0, rs}, 32'd1);
    check({tag, "_we"}, {31'b0, cwe}, 32'd1);
    check({tag, "_addr"}, ca, {addr[31:2], 2'b00});
    check({tag, "_wdata"}, cwd, data);
    @(negedge CLK);
    MemWrite = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check({tag, "_single_write"}, beats, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    RST = 1'b1; address = '0; writeData = '0; MemRead = 1'b0; MemWrite = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("rst_hit", {31'b0, hit}, 32'd1);
    check("rst_rdata", readData, 32'h0);
    check("rst_req", {31'b0, memReq}, 32'd0);
    check("rst_we", {31'b0, memWe}, 32'd0);
    check("rst_addr", memAddr, 32'h0);
    check("rst_wdata", memWriteData, 32'h0);
    RST = 1'b0;

    do_load("t1_miss", 32'h40, 4);
    do_load("t2_hit", 32'h48, 0);
    do_store("t3_store", 32'h44, 32'hDEAD_BEEF);
    do_load("t3_rd", 32'h44, 0);
    do_store("t4_store", 32'h1000, 32'hCAFE_F00D);
    do_load("t4_noalloc", 32'h1000, 4);
    do_load("t5_hit", 32'h40, 0);
    do_load("t5_conflict", 32'h40 + NL * WPB * 4, 4);
    do_load("t5_reread", 32'h40, 4);

    // Reset in the middle of a fill.
    @(negedge CLK);
    address = 32'h300; MemRead = 1'b1; beats = 0;
    #1;
    cnt = 0;
    while (beats < 2 && cnt < 64) begin
      @(negedge CLK);
      #1;
      cnt++;
    end
    check("t6_two_beats", beats, 2);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    check("t6_req_drop", {31'b0, memReq}, 32'd0);
    check("t6_miss_after_rst", {31'b0, hit}, 32'd0);
    RST = 1'b0; MemRead = 1'b0;
    do_load("t6_refill", 32'h300, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
